riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles a grant waits for m_ready.
REQ-004 clk  in  1  rising-edge clock; reset rst, synchronous, active-low.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 i_req  in  1  instruction-fetch request, held until i_ack.
REQ-007 i_addr  in  AW  fetch address, stable while i_req is high.
REQ-008 i_rdata  out  DW  fetch data, valid when i_ack is high.
REQ-009 i_ack  out  1  one-cycle completion pulse, fetch port.
REQ-010 d_req  in  1  data request, held until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  AW  data address, stable while d_req is high.
REQ-013 d_wdata  in  DW  store data.
REQ-014 d_rdata  out  DW  load data, valid when d_ack is high.
REQ-015 d_ack  out  1  one-cycle completion pulse, data port.
REQ-016 m_en  out  1  shared memory enable.
REQ-017 m_rw  out  1  1 = write, matching the core's rw polarity.
REQ-018 m_addr  out  AW  shared memory address.
REQ-019 m_wdata  out  DW  shared memory write data.
REQ-020 m_rdata  in  DW  memory read data, valid with m_ready.
REQ-021 m_ready  in  1  memory completion, single cycle.
REQ-022 bus_err  out  1  one-cycle pulse alongside an ack when a transfer is aborted.

Function
REQ-023 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE -> BUSY on any request.
- BUSY -> RESP on m_ready or on timeout.
- RESP -> IDLE unconditionally.
REQ-024 In IDLE with exactly one request, SHALL grant that port and register its address, we and wdata into the m_* outputs; m_en rises the next cycle.
REQ-025 On simultaneous i_req and d_req, SHALL grant the port that did not win the last grant (round-robin pointer last_grant).
REQ-026 In BUSY, SHALL hold m_en=1 and m_addr, m_rw and m_wdata constant until m_ready is sampled high.
REQ-027 On m_ready, SHALL register m_rdata into the granted port's rdata and drop m_en the same edge.
REQ-028 In RESP, SHALL pulse the granted port's ack for exactly one cycle; the other ack stays 0.
REQ-029 SHALL update last_grant at the edge leaving RESP.
REQ-030 Minimum latency SHALL be 3 cycles from req sampled to ack when m_ready is high in the first BUSY cycle.
REQ-031 SHALL NOT re-grant a port in the cycle its ack is high; a req still high in IDLE counts as a new request.
REQ-032 A req dropped mid-transfer SHALL NOT abort the transfer; the ack is still pulsed.
REQ-033 m_ready outside BUSY SHALL be ignored.
REQ-034 i_rdata and d_rdata SHALL hold their last value between acks.
REQ-035 The fetch port SHALL always issue m_rw=0 and m_wdata=0.

Reset
REQ-036 While rst=0 at a clock edge, SHALL force:
- state to IDLE, last_grant to D (so fetch wins the first tie);
- m_en, m_rw, m_addr, m_wdata, i_ack, d_ack, bus_err and both rdata outputs to 0;
- the timeout counter to 0.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer with no ack.

Configuration
REQ-038 Macro ARB_TIMEOUT_EN:
- Defined: a counter runs in BUSY. When it reaches TIMEOUT_CYC without m_ready, the FSM enters RESP with rdata forced to 0, and the ack and bus_err pulse together.
- Undefined: BUSY waits indefinitely, no counter is built, and bus_err is tied 0.

Structure
REQ-039 Package riscv_mem_pkg SHALL hold the FSM state enum, the port IDs PORT_I=0 and PORT_D=1, and the default TIMEOUT_CYC.
REQ-040 No sub-module; round-robin select and timeout counter SHALL be inline.

Verification
REQ-041 i_req only, i_addr=0x80000000, m_ready one cycle after m_en, m_rdata=0x00000013 -> i_ack at cycle 3, i_rdata=0x00000013, m_rw=0.
REQ-042 d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> m_rw=1, m_wdata=0xDEADBEEF, d_ack once, i_ack stays 0.
REQ-043 i_req and d_req both held high after reset -> grants in order I, D, I, D; no port wins twice in a row.
REQ-044 m_ready held low, ARB_TIMEOUT_EN defined, TIMEOUT_CYC=8 -> after 8 BUSY cycles d_ack=1, bus_err=1, d_rdata=0.
REQ-045 rst=0 asserted in BUSY -> next cycle m_en=0, no ack, state IDLE; a later request is served normally.

Source files
------------

// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_pkg: shared types for the instruction/data memory arbiter.
//   arb_state_e         - arbiter FSM states (IDLE, BUSY, RESP)
//   port_e              - requesting port IDs (PORT_I = fetch, PORT_D = data)
//   TIMEOUT_CYC_DEFAULT - default BUSY timeout in cycles
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 64;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: bundles the fetch port (i_*), data port (d_*),
// shared memory port (m_*) and bus_err of the memory arbiter.
//   slave  - arbiter view: takes requests and memory responses, drives acks,
//            read data, the m_* command and bus_err
//   master - environment view (core ports + memory), the mirror of slave
interface riscv_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          m_en;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    logic          bus_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_rdata, i_ack, d_rdata, d_ack, m_en, m_rw, m_addr, m_wdata, bus_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_rw, m_addr, m_wdata, bus_err
    );

endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin arbiter sharing one single-cycle-handshake
// memory between the fetch port and the data port.
//   clk - rising-edge clock
//   rst - synchronous, active-low reset
//   bus - riscv_mem_arbiter_if.slave (i_*, d_*, m_*, bus_err)
// Build option: define ARB_TIMEOUT_EN to abort a BUSY transfer after
// TIMEOUT_CYC cycles without m_ready (ack + bus_err, rdata forced to 0).
// Without it BUSY waits indefinitely and bus_err is tied low.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    riscv_mem_arbiter_if.slave bus
);

    arb_state_e    state_q, state_d;
    port_e         last_grant_q, last_grant_d;
    port_e         grant_q, grant_d;
    logic          m_en_q, m_en_d;
    logic          m_rw_q, m_rw_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    // cnt_q counts completed BUSY cycles; the last allowed one aborts.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        m_en_d       = m_en_q;
        m_rw_d       = m_rw_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        bus_err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    if (bus.i_req && bus.d_req) begin
                        grant_d = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
                    end else begin
                        grant_d = bus.i_req ? PORT_I : PORT_D;
                    end
                    if (grant_d == PORT_I) begin
                        m_addr_d  = bus.i_addr;
                        m_rw_d    = 1'b0;
                        m_wdata_d = '0;
                    end else begin
                        m_addr_d  = bus.d_addr;
                        m_rw_d    = bus.d_we;
                        m_wdata_d = bus.d_wdata;
                    end
                    m_en_d  = 1'b1;
                    state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                // m_ready takes priority over a coincident timeout.
                if (bus.m_ready || timeout) begin
                    m_en_d  = 1'b0;
                    state_d = ST_RESP;
                    if (grant_q == PORT_I) begin
                        i_rdata_d = bus.m_ready ? bus.m_rdata : '0;
                        i_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = bus.m_ready ? bus.m_rdata : '0;
                        d_ack_d   = 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    bus_err_d = !bus.m_ready;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_D;
            grant_q      <= PORT_I;
            m_en_q       <= 1'b0;
            m_rw_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= '0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            m_en_q       <= m_en_d;
            m_rw_q       <= m_rw_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            bus_err_q    <= bus_err_d;
`endif
        end
    end

    assign bus.m_en    = m_en_q;
    assign bus.m_rw    = m_rw_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.bus_err = bus_err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: drives riscv_mem_arbiter through directed scenarios
// and a randomized phase, checking every cycle against a transaction-level
// reference model of the arbiter's rules.
module tb_riscv_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    riscv_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    riscv_mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one outstanding transaction record plus held outputs.
    bit            t_live, t_resp, t_port, rr_last;
    int unsigned   t_age;
    logic          e_men, e_rw, e_iack, e_dack, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_irdata, e_drdata;
    int            ack_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_finish(input logic [DW-1:0] data, input bit err);
        t_live = 1'b0;
        t_resp = 1'b1;
        e_men  = 1'b0;
        e_err  = err;
        if (t_port) begin
            e_dack   = 1'b1;
            e_drdata = data;
        end else begin
            e_iack   = 1'b1;
            e_irdata = data;
        end
    endtask

    // Predicts the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        if (!rst) begin
            t_live = 1'b0; t_resp = 1'b0; rr_last = 1'b1; t_age = 0;
            e_men = 1'b0; e_rw = 1'b0; e_iack = 1'b0; e_dack = 1'b0; e_err = 1'b0;
            e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
            return;
        end
        e_iack = 1'b0;
        e_dack = 1'b0;
        e_err  = 1'b0;
        if (t_resp) begin
            t_resp  = 1'b0;
            rr_last = t_port;
        end else if (t_live) begin
            t_age++;
            if (bus.m_ready)
                model_finish(bus.m_rdata, 1'b0);
            else if (TIMEOUT_ON && t_age >= TO)
                model_finish('0, 1'b1);
        end else if (bus.i_req || bus.d_req) begin
            t_port = (bus.i_req && bus.d_req) ? !rr_last : bus.d_req;
            t_live = 1'b1;
            t_age  = 0;
            e_men  = 1'b1;
            if (t_port) begin
                e_addr = bus.d_addr; e_rw = bus.d_we; e_wdata = bus.d_wdata;
            end else begin
                e_addr = bus.i_addr; e_rw = 1'b0;     e_wdata = '0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("m_en",    64'(bus.m_en),    64'(e_men));
        check_eq("m_rw",    64'(bus.m_rw),    64'(e_rw));
        check_eq("m_addr",  64'(bus.m_addr),  64'(e_addr));
        check_eq("m_wdata", 64'(bus.m_wdata), 64'(e_wdata));
        check_eq("i_ack",   64'(bus.i_ack),   64'(e_iack));
        check_eq("d_ack",   64'(bus.d_ack),   64'(e_dack));
        check_eq("i_rdata", 64'(bus.i_rdata), 64'(e_irdata));
        check_eq("d_rdata", 64'(bus.d_rdata), 64'(e_drdata));
        check_eq("bus_err", 64'(bus.bus_err), 64'(e_err));
        if (bus.i_ack) ack_log.push_back(0);
        if (bus.d_ack) ack_log.push_back(1);
    endtask

    task automatic new_i();
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
    endtask

    task automatic new_d();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ready = 1'b0; bus.m_rdata = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst m_en", 64'(bus.m_en), 64'(0));
        check_eq("rst acks", 64'({bus.i_ack, bus.d_ack}), 64'(0));

        // Both ports held high from reset: strict alternation starting with fetch
        rst = 1'b1;
        ack_log.delete();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_2000; bus.d_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            bus.m_ready = bus.m_en;
            bus.m_rdata = 32'h1000 + 32'(k);
        end
        check_eq("rr count", 64'(ack_log.size()), 64'(4));
        if (ack_log.size() == 4) begin
            check_eq("rr g0", 64'(ack_log[0]), 64'(0));
            check_eq("rr g1", 64'(ack_log[1]), 64'(1));
            check_eq("rr g2", 64'(ack_log[2]), 64'(0));
            check_eq("rr g3", 64'(ack_log[3]), 64'(1));
        end
        idle_inputs();
        tick();
        tick();

        // Single fetch, minimum latency
        bus.i_req = 1'b1; bus.i_addr = 32'h8000_0000;
        tick();
        check_eq("fetch m_en", 64'(bus.m_en), 64'(1));
        check_eq("fetch m_rw", 64'(bus.m_rw), 64'(0));
        bus.m_ready = 1'b1; bus.m_rdata = 32'h0000_0013;
        tick();
        check_eq("fetch i_ack", 64'(bus.i_ack), 64'(1));
        check_eq("fetch i_rdata", 64'(bus.i_rdata), 64'(32'h0000_0013));
        idle_inputs();
        tick();
        check_eq("fetch ack pulse", 64'(bus.i_ack), 64'(0));

        // Single store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("store m_rw", 64'(bus.m_rw), 64'(1));
        check_eq("store m_wdata", 64'(bus.m_wdata), 64'(32'hDEAD_BEEF));
        bus.m_ready = 1'b1; bus.m_rdata = 32'h55AA_55AA;
        tick();
        check_eq("store d_ack", 64'(bus.d_ack), 64'(1));
        check_eq("store i_ack", 64'(bus.i_ack), 64'(0));
        idle_inputs();
        tick();
        check_eq("store ack pulse", 64'(bus.d_ack), 64'(0));

        // Memory never answers
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < int'(TO); k++) begin
            tick();
            check_eq("to wait d_ack", 64'(bus.d_ack), 64'(0));
        end
        tick();
        check_eq("to d_ack", 64'(bus.d_ack), 64'(1));
        check_eq("to bus_err", 64'(bus.bus_err), 64'(1));
        check_eq("to d_rdata", 64'(bus.d_rdata), 64'(0));
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("stall d_ack", 64'(bus.d_ack), 64'(0));
            check_eq("stall m_en", 64'(bus.m_en), 64'(1));
        end
        bus.m_ready = 1'b1; bus.m_rdata = 32'h77;
        tick();
        check_eq("stall d_rdata", 64'(bus.d_rdata), 64'(32'h77));
`endif
        idle_inputs();
        tick();

        // Reset while BUSY abandons the transfer
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        tick();
        rst = 1'b0;
        tick();
        check_eq("rstbusy m_en", 64'(bus.m_en), 64'(0));
        check_eq("rstbusy i_ack", 64'(bus.i_ack), 64'(0));
        rst = 1'b1;
        bus.i_req = 1'b0;
        tick();
        check_eq("rstbusy no ack", 64'(bus.i_ack), 64'(0));
        bus.i_req = 1'b1; bus.i_addr = 32'h400;
        tick();
        bus.m_ready = 1'b1; bus.m_rdata = 32'h99;
        tick();
        check_eq("post-rst i_ack", 64'(bus.i_ack), 64'(1));
        check_eq("post-rst i_rdata", 64'(bus.i_rdata), 64'(32'h99));
        idle_inputs();
        tick();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if (bus.i_req) begin
                if (bus.i_ack) begin
                    if ($urandom_range(3) == 0) new_i(); else bus.i_req = 1'b0;
                end else if (t_live && !t_port && $urandom_range(19) == 0) begin
                    bus.i_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                new_i();
            end
            if (bus.d_req) begin
                if (bus.d_ack) begin
                    if ($urandom_range(3) == 0) new_d(); else bus.d_req = 1'b0;
                end else if (t_live && t_port && $urandom_range(19) == 0) begin
                    bus.d_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                new_d();
            end
            bus.m_ready = bus.m_en ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            bus.m_rdata = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
